// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Field limits and widths for the hh:mm:ss.mmm stopwatch count. Imported by
// stopwatch_core and btn_edge_sync.
package stopwatch_pkg;

  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  localparam int MS_W  = 10;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync
// Brings an asynchronous button level into the clk domain through a 2-flop
// synchroniser and turns each rising edge into a one-cycle pulse.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   i_btn    in   asynchronous button level
//   o_pulse  out  one-cycle pulse per rising edge of i_btn
module btn_edge_sync
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // All flops clear on reset, so a button already held at release still
  // produces exactly one pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
// Stopwatch timebase and hh:mm:ss.mmm counter. Divides clk into 1 ms ticks,
// runs/stops on st_signal rising edges, optionally freezes the display at a
// split on lap_signal rising edges, and flags overflow past
// HOURS_MAX:59:59.999 (wrap or saturate, chosen by WRAP).
// Configuration macro: STOPWATCH_LAP_EN enables the lap/split logic; without
// it lap_signal is unused, lap_active is 0 and the display always follows.
// Parameters: CLK_DIV (clk cycles per ms, >= 2), HOURS_W, HOURS_MAX, WRAP.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   st_signal    in   start/stop button (asynchronous)
//   lap_signal   in   lap button (asynchronous)
//   clr          in   synchronous clear (clk-synchronous level)
//   hours        out  displayed hours
//   minutes      out  displayed minutes 0..59
//   seconds      out  displayed seconds 0..59
//   milliseconds out  displayed milliseconds 0..999
//   running      out  count is advancing
//   lap_active   out  display frozen at a split
//   overflow     out  sticky overflow flag
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int HOURS_W   = 4,
  parameter int HOURS_MAX = 15,
  parameter int WRAP      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st_signal,
  input  logic               lap_signal,
  input  logic               clr,
  output logic [HOURS_W-1:0] hours,
  output logic [MIN_W-1:0]   minutes,
  output logic [SEC_W-1:0]   seconds,
  output logic [MS_W-1:0]    milliseconds,
  output logic               running,
  output logic               lap_active,
  output logic               overflow
);

  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  logic               r_running;
  logic               r_overflow;
  logic [PRESC_W-1:0] r_presc;

  logic [HOURS_W-1:0] r_liveHours;
  logic [MIN_W-1:0]   r_liveMin;
  logic [SEC_W-1:0]   r_liveSec;
  logic [MS_W-1:0]    r_liveMs;

  logic [HOURS_W-1:0] r_dispHours;
  logic [MIN_W-1:0]   r_dispMin;
  logic [SEC_W-1:0]   r_dispSec;
  logic [MS_W-1:0]    r_dispMs;

  logic [HOURS_W-1:0] w_nextHours;
  logic [MIN_W-1:0]   w_nextMin;
  logic [SEC_W-1:0]   w_nextSec;
  logic [MS_W-1:0]    w_nextMs;

  logic w_stPulse;
  logic w_prescWrap;
  logic w_tick;
  logic w_msWrap;
  logic w_secWrap;
  logic w_minWrap;
  logic w_atMax;
  logic w_stLocked;
  logic w_freezeHold;

  btn_edge_sync u_stSync (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (st_signal),
    .o_pulse (w_stPulse)
  );

  assign w_prescWrap = (r_presc == PRESC_LAST);
  assign w_tick      = r_running && w_prescWrap;
  assign w_msWrap    = (r_liveMs  == MS_W'(MS_MAX));
  assign w_secWrap   = (r_liveSec == SEC_W'(SEC_MAX));
  assign w_minWrap   = (r_liveMin == MIN_W'(MIN_MAX));
  assign w_atMax     = (r_liveHours == HOURS_W'(HOURS_MAX)) && w_minWrap && w_secWrap && w_msWrap;
  // A saturated count stays stopped until clr releases it.
  assign w_stLocked  = (WRAP == 0) && r_overflow;

  // Ripple-carry increment of the live count; overflow at the top is
  // handled separately in the sequential block.
  always_comb begin
    w_nextMs    = r_liveMs + 1'b1;
    w_nextSec   = r_liveSec;
    w_nextMin   = r_liveMin;
    w_nextHours = r_liveHours;
    if (w_msWrap) begin
      w_nextMs  = '0;
      w_nextSec = r_liveSec + 1'b1;
      if (w_secWrap) begin
        w_nextSec = '0;
        w_nextMin = r_liveMin + 1'b1;
        if (w_minWrap) begin
          w_nextMin   = '0;
          w_nextHours = r_liveHours + 1'b1;
        end
      end
    end
  end

  // The prescaler only advances while running, so pausing keeps the partial
  // millisecond. Overflow handling outranks the start/stop toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_running   <= 1'b0;
      r_overflow  <= 1'b0;
      r_presc     <= '0;
      r_liveHours <= '0;
      r_liveMin   <= '0;
      r_liveSec   <= '0;
      r_liveMs    <= '0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_presc     <= '0;
      r_liveHours <= '0;
      r_liveMin   <= '0;
      r_liveSec   <= '0;
      r_liveMs    <= '0;
      if (w_stPulse) begin
        r_running <= ~r_running;
      end
    end else begin
      if (r_running) begin
        r_presc <= w_prescWrap ? '0 : r_presc + 1'b1;
      end
      if (w_tick && w_atMax) begin
        r_overflow <= 1'b1;
        if (WRAP != 0) begin
          r_liveHours <= '0;
          r_liveMin   <= '0;
          r_liveSec   <= '0;
          r_liveMs    <= '0;
        end
      end else if (w_tick) begin
        r_liveHours <= w_nextHours;
        r_liveMin   <= w_nextMin;
        r_liveSec   <= w_nextSec;
        r_liveMs    <= w_nextMs;
      end
      if (w_tick && w_atMax && (WRAP == 0)) begin
        r_running <= 1'b0;
      end else if (w_stPulse && !w_stLocked) begin
        r_running <= ~r_running;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic w_lapPulse;
  logic r_lapActive;

  btn_edge_sync u_lapSync (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (lap_signal),
    .o_pulse (w_lapPulse)
  );

  // A pulse while frozen always releases; a pulse while unfrozen only
  // freezes if the count is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lapActive <= 1'b0;
    end else if (clr) begin
      r_lapActive <= 1'b0;
    end else if (w_lapPulse) begin
      r_lapActive <= ~r_lapActive & r_running;
    end
  end

  // The display keeps loading the live count on the freezing edge itself,
  // which captures the pre-tick value, and only holds afterwards.
  assign w_freezeHold = r_lapActive && !w_lapPulse;
  assign lap_active   = r_lapActive;
`else
  logic w_unusedLap;

  assign w_unusedLap  = lap_signal;
  assign w_freezeHold = 1'b0;
  assign lap_active   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dispHours <= '0;
      r_dispMin   <= '0;
      r_dispSec   <= '0;
      r_dispMs    <= '0;
    end else if (clr) begin
      r_dispHours <= '0;
      r_dispMin   <= '0;
      r_dispSec   <= '0;
      r_dispMs    <= '0;
    end else if (!w_freezeHold) begin
      r_dispHours <= r_liveHours;
      r_dispMin   <= r_liveMin;
      r_dispSec   <= r_liveSec;
      r_dispMs    <= r_liveMs;
    end
  end

  assign hours        = r_dispHours;
  assign minutes      = r_dispMin;
  assign seconds      = r_dispSec;
  assign milliseconds = r_dispMs;
  assign running      = r_running;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
// Drives a wrapping (WRAP=1) and a saturating (WRAP=0) stopwatch_core from
// the same buttons and checks both every cycle against a model that keeps
// the count as a plain millisecond total. Directed literals pin the model.
module tb_stopwatch_core;

  localparam int CLK_DIV   = 4;
  localparam int HOURS_W   = 4;
  localparam int HOURS_MAX = 1;
  localparam int MAX_TOTAL = (HOURS_MAX * 3600 + 59 * 60 + 59) * 1000 + 999;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stSignal = 1'b0;
  logic lapSignal = 1'b0;
  logic clr = 1'b0;

  logic [HOURS_W-1:0] hoursW, hoursS;
  logic [5:0] minW, minS, secW, secS;
  logic [9:0] msW, msS;
  logic runW, runS, lapW, lapS, ovfW, ovfS;

  logic [HOURS_W-1:0] pHours;
  logic [5:0] pMin, pSec;
  logic [9:0] pMs;

  int vectors = 0;
  int miscompares = 0;

  // Model state, index 0 = wrapping instance, 1 = saturating instance.
  int mLive[2];
  int mDisp[2];
  int mPresc[2];
  bit mRun[2];
  bit mLap[2];
  bit mOvf[2];
  bit [2:0] stHist;
  bit [2:0] lapHist;

  always #5 clk = ~clk;

  stopwatch_core #(.CLK_DIV(CLK_DIV), .HOURS_W(HOURS_W), .HOURS_MAX(HOURS_MAX), .WRAP(1)) dutWrap (
    .clk(clk), .reset(reset), .st_signal(stSignal), .lap_signal(lapSignal), .clr(clr),
    .hours(hoursW), .minutes(minW), .seconds(secW), .milliseconds(msW),
    .running(runW), .lap_active(lapW), .overflow(ovfW)
  );

  stopwatch_core #(.CLK_DIV(CLK_DIV), .HOURS_W(HOURS_W), .HOURS_MAX(HOURS_MAX), .WRAP(0)) dutSat (
    .clk(clk), .reset(reset), .st_signal(stSignal), .lap_signal(lapSignal), .clr(clr),
    .hours(hoursS), .minutes(minS), .seconds(secS), .milliseconds(msS),
    .running(runS), .lap_active(lapS), .overflow(ovfS)
  );

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mLive[i] = 0; mDisp[i] = 0; mPresc[i] = 0;
      mRun[i] = 1'b0; mLap[i] = 1'b0; mOvf[i] = 1'b0;
    end
    stHist = '0;
    lapHist = '0;
  endtask

  // One clock edge of the stopwatch rules, applied to a millisecond total.
  // A button edge sampled at edge k acts at edge k+2.
  task automatic modelStep();
    bit stP, lapP, tick, locked, run0, wrap;
    stP = stHist[1] & ~stHist[2];
    lapP = lapHist[1] & ~lapHist[2];
    stHist = {stHist[1:0], stSignal};
    lapHist = {lapHist[1:0], lapSignal};
    for (int i = 0; i < 2; i++) begin
      wrap = (i == 0);
      run0 = mRun[i];
      tick = run0 && (mPresc[i] == CLK_DIV - 1);
      if (clr) begin
        mLive[i] = 0; mPresc[i] = 0; mDisp[i] = 0; mLap[i] = 1'b0; mOvf[i] = 1'b0;
        if (stP) mRun[i] = !run0;
      end else begin
        locked = !wrap && mOvf[i];
        if (!(LAP_EN && mLap[i] && !lapP)) mDisp[i] = mLive[i];
        if (LAP_EN && lapP) mLap[i] = mLap[i] ? 1'b0 : run0;
        if (run0) mPresc[i] = (mPresc[i] + 1) % CLK_DIV;
        if (stP && !locked) mRun[i] = !run0;
        if (tick) begin
          if (mLive[i] == MAX_TOTAL) begin
            mOvf[i] = 1'b1;
            if (wrap) mLive[i] = 0;
            else mRun[i] = 1'b0;
          end else begin
            mLive[i] = mLive[i] + 1;
          end
        end
      end
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) modelReset();
      else modelStep();
    end
  end

  task automatic compareField(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input int h, input int m,
                             input int s, input int ms, input bit run, input bit lap, input bit ovf);
    int d;
    d = mDisp[idx];
    vectors++;
    compareField({tag, ".hours"}, h, d / 3600000);
    compareField({tag, ".minutes"}, m, (d / 60000) % 60);
    compareField({tag, ".seconds"}, s, (d / 1000) % 60);
    compareField({tag, ".milliseconds"}, ms, d % 1000);
    compareField({tag, ".running"}, int'(run), int'(mRun[idx]));
    compareField({tag, ".lap_active"}, int'(lap), int'(mLap[idx]));
    compareField({tag, ".overflow"}, int'(ovf), int'(mOvf[idx]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("wrap", 0, int'(hoursW), int'(minW), int'(secW), int'(msW), runW, lapW, ovfW);
      checkOutput("sat", 1, int'(hoursS), int'(minS), int'(secS), int'(msS), runS, lapS, ovfS);
    end
  end

  task automatic expectLit(input string name, input int act, input int exp);
    vectors++;
    compareField(name, act, exp);
  endtask

  task automatic applyStimulus(input bit st, input bit lap, input bit c);
    stSignal = st;
    lapSignal = lap;
    clr = c;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Loads a live count into both instances and the model between edges.
  task automatic preload(input int v);
    pHours = HOURS_W'(v / 3600000);
    pMin = 6'((v / 60000) % 60);
    pSec = 6'((v / 1000) % 60);
    pMs = 10'(v % 1000);
    force dutWrap.r_liveHours = pHours;
    force dutWrap.r_liveMin = pMin;
    force dutWrap.r_liveSec = pSec;
    force dutWrap.r_liveMs = pMs;
    force dutSat.r_liveHours = pHours;
    force dutSat.r_liveMin = pMin;
    force dutSat.r_liveSec = pSec;
    force dutSat.r_liveMs = pMs;
    mLive[0] = v;
    mLive[1] = v;
    #1;
    release dutWrap.r_liveHours;
    release dutWrap.r_liveMin;
    release dutWrap.r_liveSec;
    release dutWrap.r_liveMs;
    release dutSat.r_liveHours;
    release dutSat.r_liveMin;
    release dutSat.r_liveSec;
    release dutSat.r_liveMs;
  endtask

  initial begin
    #2 reset = 1'b0;
    waitCycles(3);
    expectLit("reset.ms", int'(msW), 0);
    expectLit("reset.running", int'(runW), 0);
    expectLit("reset.overflow", int'(ovfS), 0);
    reset = 1'b1;

    // Start: running rises two edges after the sampling edge, first tick
    // CLK_DIV edges later, display one edge after that.
    applyStimulus(1, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(1);
    expectLit("start.runningEarly", int'(runW), 0);
    waitCycles(1);
    expectLit("start.running", int'(runW), 1);
    expectLit("start.runningSat", int'(runS), 1);
    waitCycles(4);
    expectLit("start.msBeforeDisplay", int'(msW), 0);
    waitCycles(1);
    expectLit("start.firstMs", int'(msW), 1);

    // Pause with the prescaler at 2, then resume.
    waitCycles(2);
    applyStimulus(1, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(2);
    expectLit("pause.running", int'(runW), 0);
    waitCycles(20);
    expectLit("pause.msHeld", int'(msW), 2);
    applyStimulus(1, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(4);
    expectLit("resume.msNotYet", int'(msW), 2);
    waitCycles(1);
    expectLit("resume.msNext", int'(msW), 3);

    // Lap at ms=5, hold while the live count reaches 40, release.
    waitCycles(5);
    applyStimulus(0, 1, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(2);
    expectLit("lap.active", int'(lapW), int'(LAP_EN));
    expectLit("lap.capture", int'(msW), 5);
    waitCycles(140);
    expectLit("lap.frozen", int'(msW), LAP_EN ? 5 : 40);
    applyStimulus(0, 1, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(2);
    expectLit("lap.released", int'(lapW), 0);
    expectLit("lap.follow", int'(msW), 40);

    // Carry chain.
    preload(59999);
    waitCycles(5);
    expectLit("carry.minute", int'(minW), 1);
    expectLit("carry.second", int'(secW), 0);
    expectLit("carry.ms", int'(msW), 0);
    preload(3599999);
    waitCycles(5);
    expectLit("carry.hour", int'(hoursW), 1);
    expectLit("carry.hourMin", int'(minW), 0);

    // Overflow: wrap vs saturate.
    preload(MAX_TOTAL);
    waitCycles(5);
    expectLit("wrap.hours", int'(hoursW), 0);
    expectLit("wrap.overflow", int'(ovfW), 1);
    expectLit("wrap.running", int'(runW), 1);
    expectLit("sat.hours", int'(hoursS), 1);
    expectLit("sat.minutes", int'(minS), 59);
    expectLit("sat.ms", int'(msS), 999);
    expectLit("sat.overflow", int'(ovfS), 1);
    expectLit("sat.running", int'(runS), 0);
    applyStimulus(1, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(3);
    expectLit("sat.stIgnored", int'(runS), 0);
    expectLit("wrap.stopped", int'(runW), 0);
    applyStimulus(0, 0, 1);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    expectLit("sat.clrOverflow", int'(ovfS), 0);
    expectLit("sat.clrHours", int'(hoursS), 0);
    expectLit("sat.clrMs", int'(msS), 0);

    // clr together with an st pulse while running.
    applyStimulus(1, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(10);
    expectLit("restart.running", int'(runS), 1);
    applyStimulus(1, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    waitCycles(1);
    applyStimulus(0, 0, 1);
    waitCycles(1);
    applyStimulus(0, 0, 0);
    expectLit("clrSt.ms", int'(msW), 0);
    expectLit("clrSt.running", int'(runW), 0);

    // Randomised buttons, clears and boundary preloads.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      int off;
      if ($urandom_range(0, 15) == 0) stSignal = ~stSignal;
      if ($urandom_range(0, 15) == 0) lapSignal = ~lapSignal;
      clr = ($urandom_range(0, 79) == 0);
      if ((c % 400) == 200) begin
        sel = int'($urandom_range(0, 2));
        off = int'($urandom_range(0, 30));
        case (sel)
          0: preload(59999 - off);
          1: preload(3599999 - off);
          default: preload(MAX_TOTAL - off);
        endcase
      end
      waitCycles(1);
    end

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(0, 0, 0);
    waitCycles(5);
    if (!mRun[0]) begin
      applyStimulus(1, 0, 0);
      waitCycles(1);
      applyStimulus(0, 0, 0);
    end
    waitCycles(30);
    #1 reset = 1'b0;
    #1;
    expectLit("asyncReset.ms", int'(msW), 0);
    expectLit("asyncReset.seconds", int'(secW), 0);
    expectLit("asyncReset.running", int'(runW), 0);
    expectLit("asyncReset.overflow", int'(ovfW), 0);
    expectLit("asyncReset.lap", int'(lapW), 0);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
